alu_decoder: RTL and testbench

ALU_DECODER -- requirements
Module: alu_decoder

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/alu_op_decode.sv | 74 +++++++
 rtl/alu_decoder.sv | 85 ++++++++
 tb/tb_alu_decoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode/funct constants, ALU control enum and decoded-instruction struct
package riscv_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011
  } alu_ctrl_e;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  typedef struct packed {
    alu_ctrl_e   alu_ctrl;
    logic        alu_src_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        branch_ne;
    logic        illegal;
  } decoded_t;
  function automatic alu_ctrl_e f3_alu(logic [2:0] f3);
    return f3 == F3_AND ? ALU_AND : f3 == F3_OR ? ALU_OR : ALU_ADD;
  endfunction
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational RV32I subset decode into the packed decoded_t struct
module alu_op_decode
  import riscv_pkg::*;
(
  input  logic [31:0] i_instr,
  output decoded_t    o_dec
);
  logic [6:0]  w_op;
  logic [6:0]  w_f7;
  logic [2:0]  w_f3;
  logic        w_f3_alu;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  assign w_op     = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_f3_alu = (w_f3 == F3_ADD) || (w_f3 == F3_AND) || (w_f3 == F3_OR);
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  // Unused register fields stay 0 so each format only exposes the indices it really has.
  always_comb begin
    o_dec = '0;
    o_dec.illegal = 1'b1;
    case (w_op)
      OP_R: if ((w_f3_alu && w_f7 == F7_BASE) || (w_f3 == F3_ADD && w_f7 == F7_SUB)) begin
        o_dec.illegal   = 1'b0;
        o_dec.alu_ctrl  = w_f7 == F7_SUB ? ALU_SUB : f3_alu(w_f3);
        o_dec.rs1       = i_instr[19:15];
        o_dec.rs2       = i_instr[24:20];
        o_dec.rd        = i_instr[11:7];
        o_dec.reg_write = 1'b1;
      end
      OP_IMM: if (w_f3_alu) begin
        o_dec.illegal     = 1'b0;
        o_dec.alu_ctrl    = f3_alu(w_f3);
        o_dec.alu_src_imm = 1'b1;
        o_dec.imm         = w_imm_i;
        o_dec.rs1         = i_instr[19:15];
        o_dec.rd          = i_instr[11:7];
        o_dec.reg_write   = 1'b1;
      end
      OP_LOAD: if (w_f3 == F3_W) begin
        o_dec.illegal     = 1'b0;
        o_dec.alu_src_imm = 1'b1;
        o_dec.imm         = w_imm_i;
        o_dec.rs1         = i_instr[19:15];
        o_dec.rd          = i_instr[11:7];
        o_dec.mem_read    = 1'b1;
        o_dec.reg_write   = 1'b1;
      end
      OP_STORE: if (w_f3 == F3_W) begin
        o_dec.illegal     = 1'b0;
        o_dec.alu_src_imm = 1'b1;
        o_dec.imm         = w_imm_s;
        o_dec.rs1         = i_instr[19:15];
        o_dec.rs2         = i_instr[24:20];
        o_dec.mem_write   = 1'b1;
      end
      OP_BRANCH: if (w_f3 == F3_BEQ || w_f3 == F3_BNE) begin
        o_dec.illegal   = 1'b0;
        o_dec.alu_ctrl  = ALU_SUB;
        o_dec.imm       = w_imm_b;
        o_dec.rs1       = i_instr[19:15];
        o_dec.rs2       = i_instr[24:20];
        o_dec.branch    = 1'b1;
        o_dec.branch_ne = w_f3 == F3_BNE;
      end
      default: ;
    endcase
    o_dec.reg_write = o_dec.reg_write && (o_dec.rd != 5'd0);
  end
endmodule

// File: rtl/alu_decoder.sv
// alu_decoder: RV32I ALU-control decoder behind a 2-entry valid/ready skid buffer
module alu_decoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src_imm,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        branch_ne,
  output logic        illegal
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
  state_e   r_state;
  decoded_t r_main;
  decoded_t r_skid;
  decoded_t w_dec;
  logic     r_in_ready;
  logic     r_out_valid;
  logic     w_push;
  logic     w_pop;
  alu_op_decode u_dec (.i_instr(instr), .o_dec(w_dec));
  assign w_push = in_valid && r_in_ready;
  assign w_pop  = r_out_valid && out_ready;
  // Decode happens at the input so both entries hold finished results; main is always the head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: if (w_push) begin
          r_main      <= w_dec;
          r_state     <= ONE;
          r_out_valid <= 1'b1;
        end
        ONE: if (w_push && !w_pop) begin
          r_skid     <= w_dec;
          r_state    <= TWO;
          r_in_ready <= 1'b0;
        end else if (w_push) begin
          r_main <= w_dec;
        end else if (w_pop) begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
        end
        TWO: if (w_pop) begin
          r_main     <= r_skid;
          r_state    <= ONE;
          r_in_ready <= 1'b1;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign alu_ctrl    = r_main.alu_ctrl;
  assign alu_src_imm = r_main.alu_src_imm;
  assign imm         = r_main.imm;
  assign rs1         = r_main.rs1;
  assign rs2         = r_main.rs2;
  assign rd          = r_main.rd;
  assign reg_write   = r_main.reg_write;
  assign mem_read    = r_main.mem_read;
  assign mem_write   = r_main.mem_write;
  assign branch      = r_main.branch;
  assign branch_ne   = r_main.branch_ne;
  assign illegal     = r_main.illegal;
endmodule

// File: tb/tb_alu_decoder.sv
// tb_alu_decoder: scoreboarded random and directed checks of alu_decoder against a mnemonic-level model
module tb_alu_decoder;
  typedef struct packed {
    logic [3:0]  alu;
    logic        src;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw, br, bne, ill;
  } exp_t;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [31:0] instr = '0;
  logic        in_ready, out_valid, alu_src_imm, reg_write, mem_read, mem_write, branch, branch_ne, illegal;
  logic [3:0]  alu_ctrl;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  exp_t        q[$];
  exp_t        held;
  logic        was_stall = 0;
  int          n_cmp = 0, n_bad = 0;
  localparam logic [31:0] I_ADD = 32'h002081B3, I_SUB = 32'h407302B3, I_ADDI = 32'hFFF00093;
  localparam logic [31:0] I_BNE = 32'h00209463, I_ORI = 32'h0050E213;

  alu_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl), .alu_src_imm(alu_src_imm),
    .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .branch_ne(branch_ne), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t got();
    return {alu_ctrl, alu_src_imm, imm, rs1, rs2, rd, reg_write, mem_read, mem_write, branch, branch_ne, illegal};
  endfunction

  // Name the instruction first, then derive every field from what that instruction means.
  function automatic exp_t model(logic [31:0] x);
    exp_t e;
    string m;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic is_r, is_i, is_l, is_s, is_b;
    e = '0;
    op = x[6:0]; f3 = x[14:12]; f7 = x[31:25];
    is_r = op == 7'h33; is_i = op == 7'h13; is_l = op == 7'h03; is_s = op == 7'h23; is_b = op == 7'h63;
    m = "bad";
    if (is_r) m = (f7 == 0 && f3 == 0) ? "add" : (f7 == 7'h20 && f3 == 0) ? "sub" :
                  (f7 == 0 && f3 == 7) ? "and" : (f7 == 0 && f3 == 6) ? "or" : "bad";
    else if (is_i) m = f3 == 0 ? "addi" : f3 == 7 ? "andi" : f3 == 6 ? "ori" : "bad";
    else if (is_l && f3 == 2) m = "lw";
    else if (is_s && f3 == 2) m = "sw";
    else if (is_b && f3 == 0) m = "beq";
    else if (is_b && f3 == 1) m = "bne";
    if (m == "bad") begin
      e.ill = 1;
      return e;
    end
    e.alu = (m == "sub" || m == "beq" || m == "bne") ? 4'd1 : (m == "and" || m == "andi") ? 4'd2 :
            (m == "or" || m == "ori") ? 4'd3 : 4'd0;
    e.src = !(is_r || is_b);
    e.imm = is_s ? 32'($signed({x[31:25], x[11:7]})) :
            is_b ? 32'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0})) :
            (is_i || is_l) ? 32'($signed(x[31:20])) : 32'd0;
    e.rs1 = x[19:15];
    if (is_r || is_s || is_b) e.rs2 = x[24:20];
    if (is_r || is_i || is_l) begin
      e.rd = x[11:7];
      e.rw = x[11:7] != 0;
    end
    e.mr = m == "lw";
    e.mw = m == "sw";
    e.br = is_b;
    e.bne = m == "bne";
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] x;
    int k;
    x = $urandom;
    k = $urandom_range(0, 5);
    x[6:0] = k == 0 ? 7'h33 : k == 1 ? 7'h13 : k == 2 ? 7'h03 : k == 3 ? 7'h23 : k == 4 ? 7'h63 : x[6:0];
    k = $urandom_range(0, 6);
    if (k < 5) x[14:12] = k == 0 ? 3'd0 : k == 1 ? 3'd1 : k == 2 ? 3'd2 : k == 3 ? 3'd6 : 3'd7;
    if (x[6:0] == 7'h33 && $urandom_range(0, 3) != 0) x[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    return x;
  endfunction

  // Monitor: pops on every output transfer before pushing this cycle's accept, so stale outputs are caught.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      was_stall = 0;
    end else begin
      if (was_stall) check("hold_stable", {out_valid, got()}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("stale_out", out_valid, 0);
        else check("scoreboard", got(), q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(model(instr));
      was_stall = out_valid && !out_ready;
      held = got();
    end
  end

  task automatic issue(logic [31:0] x);
    int t;
    t = 0;
    @(posedge clk); #1 in_valid = 1; instr = x;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("accept", in_ready, 1);
    @(posedge clk); #1 in_valid = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_fields", got(), 0);
    @(posedge clk); #1 rst_n = 1; out_ready = 1;
    issue(I_ADD);
    @(negedge clk);
    check("add_latency", out_valid, 1);
    check("add_fields", {alu_ctrl, rs1, rs2, rd, reg_write, alu_src_imm}, {4'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0});
    issue(I_SUB);
    @(negedge clk);
    check("sub_fields", {out_valid, alu_ctrl, rd, reg_write}, {1'b1, 4'd1, 5'd5, 1'b1});
    issue(I_ADDI);
    @(negedge clk);
    check("addi_fields", {out_valid, alu_ctrl, imm, alu_src_imm}, {1'b1, 4'd0, 32'hFFFFFFFF, 1'b1});
    issue(I_BNE);
    @(negedge clk);
    check("bne_fields", {out_valid, alu_ctrl, branch, branch_ne, imm, reg_write}, {1'b1, 4'd1, 1'b1, 1'b1, 32'd8, 1'b0});
    issue(32'h0);
    @(negedge clk);
    check("illegal_fields", {out_valid, illegal, alu_ctrl, alu_src_imm, reg_write, mem_read, mem_write, branch, branch_ne},
          {1'b1, 1'b1, 4'd0, 6'd0});
    // Backpressure: two accepts fill the buffer, the third instruction must wait.
    @(posedge clk); #1 out_ready = 0; in_valid = 1; instr = I_ADD;
    @(posedge clk); #1 instr = I_SUB;
    @(posedge clk); #1 instr = I_ORI;
    @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_head_add", {out_valid, alu_ctrl}, {1'b1, 4'd0});
    repeat (3) @(negedge clk);
    check("bp_ori_held", q.size(), 2);
    @(posedge clk); #1 out_ready = 1;
    for (int t = 0; t < 50 && !(in_ready && in_valid); t++) @(negedge clk);
    check("bp_ori_accept", in_ready, 1);
    @(posedge clk); #1 in_valid = 0;
    repeat (5) @(negedge clk);
    check("bp_drained", q.size(), 0);
    // Reset with both entries occupied.
    @(posedge clk); #1 out_ready = 0; in_valid = 1; instr = I_SUB;
    @(posedge clk); #1 instr = I_ADDI;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    check("full_before_rst", in_ready, 0);
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1; out_ready = 1;
    @(negedge clk);
    check("midrst_state", {out_valid, in_ready}, {1'b0, 1'b1});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_no_stale", out_valid, 0);
    end
    // Random traffic with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      instr = rand_instr();
    end
    @(posedge clk); #1 in_valid = 0; out_ready = 1;
    for (int t = 0; t < 20 && q.size() != 0; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("final_drain", q.size(), 0);
    check("final_idle", out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
